// File: rtl/uart_tx_queue.sv
// Transmit byte queue between the bus side and the UART shifter, with occupancy,
// watermark interrupt-pending and sticky overflow. Optional flush: UART_TXQ_FLUSH_EN.
module uart_tx_queue #(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          io_enq_valid,
    output logic          io_enq_ready,
    input  logic [7:0]    io_enq_bits,
    output logic          io_deq_valid,
    input  logic          io_deq_ready,
    output logic [7:0]    io_deq_bits,
    output logic [CW-1:0] io_count,
    input  logic [CW-1:0] io_txwm,
    output logic          io_ip_txwm,
    output logic          io_ovf,
`ifdef UART_TXQ_FLUSH_EN
    input  logic          io_flush,
`endif
    input  logic          io_ovf_clr
);
    localparam int AW = $clog2(DEPTH);

    // Handshakes: a transfer happens on a rising clock edge exactly when valid and
    // ready are both high; valid never depends on ready on either side.
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] enq_ptr;
    logic [AW-1:0] deq_ptr;
    logic          maybe_full;
    logic          ptr_match;
    logic          empty;
    logic          full;
    logic          do_enq;
    logic          do_deq;
    logic          flush_req;
    logic          ovf_set;
    logic          ovf;

`ifdef UART_TXQ_FLUSH_EN
    assign flush_req = io_flush;
`else
    assign flush_req = 1'b0;
`endif

    assign ptr_match    = (enq_ptr == deq_ptr);
    assign empty        = ptr_match & ~maybe_full;
    assign full         = ptr_match & maybe_full;

    // Flush blocks both sides so nothing moves in the cycle the pointers are cleared.
    assign io_enq_ready = ~full & ~flush_req;
    assign io_deq_valid = ~empty & ~flush_req;
    assign io_deq_bits  = mem[deq_ptr];

    assign do_enq       = io_enq_valid & io_enq_ready;
    assign do_deq       = io_deq_valid & io_deq_ready;

    assign io_count     = full ? CW'(DEPTH) : {1'b0, enq_ptr - deq_ptr};
    assign io_ip_txwm   = (io_count < io_txwm);

    assign ovf_set      = io_enq_valid & ~io_enq_ready & ~flush_req;
    assign io_ovf       = ovf;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else if (flush_req) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (do_enq) enq_ptr <= enq_ptr + 1'b1;
            if (do_deq) deq_ptr <= deq_ptr + 1'b1;
            if (do_enq != do_deq) maybe_full <= do_enq;
        end
    end

    // Storage is deliberately left unreset; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (do_enq) mem[enq_ptr] <= io_enq_bits;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)           ovf <= 1'b0;
        else if (ovf_set)    ovf <= 1'b1;
        else if (io_ovf_clr) ovf <= 1'b0;
    end
endmodule
